axi_master: RTL and testbench

AXI4 burst initiator: the requesting end of the memory-mapped AXI link, and the counterpart to axi_slave.
- Accepts one command at a time from a local client over a valid/ready interface.
- Issues the AW/W/B or AR/R channel sequence for that command.
- Streams write beats in from the client, returns read beats to the client, and reports a 2-bit completion response.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_master.sv | 160 ++++++++++++++++
 tb/tb_axi_master.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared types for the AXI4 burst initiator: response codes, master FSM states
// and the burst length field width.
package axi_pkg;

    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_RADDR,
        S_RDATA
    } state_t;

endpackage

// File: rtl/axi_master.sv
// AXI4 burst initiator: takes one client command at a time and runs the AW/W/B
// or AR/R sequence for it, streaming beats to/from the client.
module axi_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic [1:0]        resp,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [LEN_W-1:0]  AWLEN,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [LEN_W-1:0]  ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    state_t            state;
    logic [LEN_W-1:0]  beat_cnt;
    logic [1:0]        rd_first;
    logic              rd_mis;
    logic              rd_end;

    logic              last_beat;
    logic              rlast_bad;
    logic [1:0]        rd_first_nxt;

    // A transfer on any channel happens on the rising edge where both VALID and
    // READY are high; a VALID, once raised, holds its payload until that edge.
    assign cmd_ready   = (state == S_IDLE);
    assign last_beat   = (beat_cnt == '0);

    assign WVALID      = (state == S_WDATA) && wdata_valid;
    assign WDATA       = wdata_in;
    assign WLAST       = (state == S_WDATA) && last_beat;
    assign wdata_ready = (state == S_WDATA) && WREADY;
    assign BREADY      = (state == S_WRESP);
    assign RREADY      = (state == S_RDATA);

    // Read status keeps the first error code seen; a misplaced RLAST overrides it.
    assign rlast_bad    = (RLAST != last_beat);
    assign rd_first_nxt = (rd_first == OKAY) ? RRESP : rd_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            AWADDR      <= '0;
            AWLEN       <= '0;
            AWVALID     <= 1'b0;
            ARADDR      <= '0;
            ARLEN       <= '0;
            ARVALID     <= 1'b0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            resp        <= '0;
            resp_valid  <= 1'b0;
            rd_first    <= '0;
            rd_mis      <= 1'b0;
            rd_end      <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            resp_valid  <= rd_end;
            rd_end      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        beat_cnt <= cmd_len;
                        rd_first <= OKAY;
                        rd_mis   <= 1'b0;
                        if (cmd_write) begin
                            AWADDR  <= cmd_addr;
                            AWLEN   <= cmd_len;
                            AWVALID <= 1'b1;
                            state   <= S_WADDR;
                        end else begin
                            ARADDR  <= cmd_addr;
                            ARLEN   <= cmd_len;
                            ARVALID <= 1'b1;
                            state   <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        state   <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (wdata_valid && WREADY) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (last_beat) begin
                            state <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (BVALID) begin
                        resp       <= BRESP;
                        resp_valid <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_RADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (RVALID) begin
                        rdata_out   <= RDATA;
                        rdata_valid <= 1'b1;
                        beat_cnt    <= beat_cnt - 1'b1;
                        rd_first    <= rd_first_nxt;
                        rd_mis      <= rd_mis | rlast_bad;
                        // The counted beat ends the burst whatever RLAST claims.
                        if (last_beat) begin
                            resp   <= (rd_mis || rlast_bad) ? SLVERR : rd_first_nxt;
                            rd_end <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master.sv
// Self-checking bench for axi_master: a bench-side AXI slave with random stalls,
// directed bursts plus a randomized mix, checked against a burst-level model.
module tb_axi_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] wdata_in;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] rdata_out;
    logic          rdata_valid;
    logic [1:0]    resp;
    logic          resp_valid;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic          AWVALID, AWREADY, ARVALID, ARREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic          WLAST, WVALID, WREADY;
    logic [1:0]    BRESP, RRESP;
    logic          BVALID, BREADY, RLAST, RVALID, RREADY;

    int            n_checks = 0;
    int            n_errors = 0;
    int            lat;
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] exp_q [$];

    axi_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_in(wdata_in), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid),
        .resp(resp), .resp_valid(resp_valid),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wdata_in = '0; wdata_valid = 0;
        AWREADY = 0; WREADY = 0; BRESP = 2'b00; BVALID = 0;
        ARREADY = 0; RDATA = '0; RRESP = 2'b00; RLAST = 0; RVALID = 0;
    endtask

    // Write burst: client streams beats with gaps, slave stalls AW/W/B.
    task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                            input int aw_wait, input int gap, input bit rnd_rdy,
                            input logic [DW-1:0] d0, input bit seq,
                            input logic [1:0] bresp, input int abort_at);
        logic [DW-1:0] data [$];
        int   beat, gap_cnt, aw_left, b_delay, cyc;
        int   aw_cnt, w_cnt, aw_bad, w_bad, w_early, w_follow;
        bit   aw_hs, w_hs, b_hs, aw_done, b_done, done;
        logic [1:0] got_resp;
        beat = 0; gap_cnt = 0; aw_left = aw_wait; cyc = 0;
        b_delay = rnd_rdy ? int'($urandom_range(0, 3)) : 0;
        aw_cnt = 0; w_cnt = 0; aw_bad = 0; w_bad = 0; w_early = 0; w_follow = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; aw_done = 0; b_done = 0; done = 0;
        got_resp = 2'b00;
        for (int i = 0; i <= int'(len); i++) data.push_back(seq ? d0 + DW'(i) : $urandom);

        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len;
        #1 check("wr_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cmd_valid = 0;
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs) begin beat++; gap_cnt = gap; end
            if (b_hs) b_done = 1;
            if (abort_at >= 0 && beat == abort_at) return;
            AWREADY = (aw_left == 0);
            if (AWVALID && aw_left > 0) aw_left--;
            if (gap_cnt > 0) begin
                wdata_valid = 0;
                gap_cnt--;
            end else begin
                wdata_valid = (beat <= int'(len));
            end
            wdata_in = (beat <= int'(len)) ? data[beat] : '0;
            WREADY = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            BVALID = (beat > int'(len)) && !b_done && (b_delay == 0);
            if (beat > int'(len) && b_delay > 0) b_delay--;
            BRESP = bresp;
            RVALID = $urandom_range(0, 1);
            #1;
            if (!aw_done && !AWVALID) aw_bad++;
            if (AWVALID && (AWADDR !== addr || AWLEN !== len)) aw_bad++;
            aw_hs = AWVALID && AWREADY;
            if (aw_hs) aw_cnt++;
            if (WVALID && !aw_done) w_early++;
            if (WVALID !== (aw_done && wdata_valid && beat <= int'(len))) w_follow++;
            if (wdata_ready !== (aw_done && WREADY && beat <= int'(len))) w_follow++;
            if (BREADY !== (beat > int'(len) && !b_done)) w_follow++;
            w_hs = WVALID && WREADY;
            if (w_hs) begin
                w_cnt++;
                if (WDATA !== data[beat] || WLAST !== (beat == int'(len))) w_bad++;
                mem[addr + AW'(4 * beat)] = WDATA;
            end
            b_hs = BVALID && BREADY;
            if (resp_valid) begin
                done = 1;
                got_resp = resp;
            end
        end
        lat = cyc;
        check("wr_completed", done, 1);
        check("wr_aw_count", aw_cnt, 1);
        check("wr_aw_stable", aw_bad, 0);
        check("wr_w_before_aw", w_early, 0);
        check("wr_w_follow", w_follow, 0);
        check("wr_w_count", w_cnt, int'(len) + 1);
        check("wr_w_data_last", w_bad, 0);
        check("wr_resp", got_resp, bresp);
        for (int i = 0; i <= int'(len); i++)
            check("wr_mem", mem.exists(addr + AW'(4 * i)) ? mem[addr + AW'(4 * i)] : 'x, data[i]);
        @(negedge clk);
        idle_inputs();
        #1 check("wr_resp_pulse", resp_valid, 0);
    endtask

    // Read burst: slave returns queued beats, optionally with a misplaced RLAST.
    task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                           input int ar_wait, input bit rnd_rdy,
                           input logic [DW-1:0] d0, input bit seq,
                           input int bad_last, input bit rnd_resp);
        logic [DW-1:0] rd [$];
        logic [1:0]    rr [$];
        bit            rl [$];
        logic [1:0]    exp_resp, got_resp;
        bit   mis, ar_hs, r_hs, ar_done, done;
        int   rbeat, ar_left, cyc, ar_cnt, ar_bad, r_follow, rv_cnt, extra, last_rv, resp_cyc;
        for (int i = 0; i <= int'(len); i++) begin
            rd.push_back(seq ? d0 + DW'(i) : $urandom);
            rr.push_back((rnd_resp && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            rl.push_back(i == int'(len));
        end
        if (bad_last >= 0) begin
            rl[bad_last] = 1;
            rl[len] = 0;
        end
        mis = 0;
        exp_resp = 2'b00;
        for (int i = 0; i <= int'(len); i++) begin
            if (rl[i] != (i == int'(len))) mis = 1;
            if (exp_resp == 2'b00) exp_resp = rr[i];
        end
        if (mis) exp_resp = 2'b10;
        exp_q.delete();
        foreach (rd[i]) exp_q.push_back(rd[i]);

        ar_hs = 0; r_hs = 0; ar_done = 0; done = 0; got_resp = 2'b00;
        rbeat = 0; ar_left = ar_wait; cyc = 0; ar_cnt = 0; ar_bad = 0;
        r_follow = 0; rv_cnt = 0; extra = 0; last_rv = -10; resp_cyc = -1;

        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = len;
        #1 check("rd_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cmd_valid = 0;
            cyc++;
            if (ar_hs) ar_done = 1;
            if (r_hs) rbeat++;
            ARREADY = (ar_left == 0);
            if (ARVALID && ar_left > 0) ar_left--;
            RVALID = ar_done && rbeat <= int'(len) && (rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
            RDATA = (rbeat <= int'(len)) ? rd[rbeat] : $urandom;
            RRESP = (rbeat <= int'(len)) ? rr[rbeat] : 2'b00;
            RLAST = (rbeat <= int'(len)) ? rl[rbeat] : 1'b0;
            BVALID = $urandom_range(0, 1);
            BRESP = 2'b11;
            wdata_valid = $urandom_range(0, 1);
            #1;
            if (!ar_done && !ARVALID) ar_bad++;
            if (ARVALID && (ARADDR !== addr || ARLEN !== len)) ar_bad++;
            ar_hs = ARVALID && ARREADY;
            if (ar_hs) ar_cnt++;
            if (RREADY !== (ar_done && rbeat <= int'(len))) r_follow++;
            if (BREADY !== 1'b0 || WVALID !== 1'b0 || AWVALID !== 1'b0) r_follow++;
            r_hs = RVALID && RREADY;
            if (rdata_valid) begin
                rv_cnt++;
                last_rv = cyc;
                if (exp_q.size() == 0) extra++;
                else check("rd_data", rdata_out, exp_q.pop_front());
            end
            if (resp_valid) begin
                done = 1;
                got_resp = resp;
                resp_cyc = cyc;
            end
        end
        check("rd_completed", done, 1);
        check("rd_ar_count", ar_cnt, 1);
        check("rd_ar_stable", ar_bad, 0);
        check("rd_ready_follow", r_follow, 0);
        check("rd_beat_count", rv_cnt, int'(len) + 1);
        check("rd_extra_beats", extra, 0);
        check("rd_left_in_queue", exp_q.size(), 0);
        check("rd_resp_timing", resp_cyc, last_rv + 1);
        check("rd_resp", got_resp, exp_resp);
        @(negedge clk);
        idle_inputs();
        #1 check("rd_resp_pulse", resp_valid, 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rdata_valid, resp_valid}, 0);
        check("rst_regs", {AWADDR, AWLEN} | {ARADDR, ARLEN} | {8'h0, rdata_out}, 0);
        check("rst_resp", resp, 0);
        @(negedge clk);
        rst = 0;

        // single beat, zero-wait slave
        do_write(32'h10, 8'd0, 0, 0, 0, 32'hDEADBEEF, 1, 2'b00, -1);
        check("wr_min_latency", lat - 1, 3);
        // four beats with client gaps
        do_write(32'h100, 8'd3, 0, 2, 0, 32'd1, 1, 2'b00, -1);
        // AW stalled five cycles
        do_write(32'h200, 8'd1, 5, 0, 0, 32'h55, 1, 2'b10, -1);
        // clean read and read with early RLAST
        do_read(32'h300, 8'd3, 0, 0, 32'hA0, 1, -1, 0);
        do_read(32'h400, 8'd3, 2, 0, 32'hB0, 1, 2, 0);

        // reset in the middle of a write burst
        do_write(32'h500, 8'd3, 0, 0, 0, 32'h70, 1, 2'b00, 2);
        rst = 1;
        wdata_valid = 1; WREADY = 1; AWREADY = 1; BVALID = 1; RVALID = 1;
        @(posedge clk);
        #1;
        check("midrst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
        check("midrst_pulses", {rdata_valid, resp_valid}, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check("postrst_stray_ignored", {resp_valid, rdata_valid, BREADY, RREADY}, 0);
        @(negedge clk);
        idle_inputs();
        do_write(32'h600, 8'd2, 1, 0, 0, 32'h90, 1, 2'b00, -1);

        // randomized mix
        for (int n = 0; n < 16; n++) begin
            automatic logic [7:0] len = 8'($urandom_range(0, 15));
            automatic logic [AW-1:0] addr = {$urandom_range(0, 255), 12'h000};
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, len, $urandom_range(0, 3), $urandom_range(0, 2), 1,
                         '0, 0, 2'($urandom_range(0, 3)), -1);
            end else begin
                do_read(addr, len, $urandom_range(0, 3), 1, '0, 0,
                        (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len) - 1)) : -1,
                        1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
